// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU tile matrix-multiply controller.
// Controller state encoding, index-width helper and default wrapper dimensions.
package tpu_pkg;

    localparam int DEF_N  = 2;
    localparam int DEF_DW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

endpackage

// File: rtl/matmul_ctrl_if.sv
// Load / start / read handshake bundle between the tile wrapper and matmul_ctrl.
interface matmul_ctrl_if
    import tpu_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DW    = DEF_DW,
    parameter int ACC_W = 2 * DW + $clog2(N),
    parameter int IW    = idx_w(N)
);

    logic             load_en;
    logic             load_sel_ab;
    logic [IW-1:0]    load_index;
    logic [DW-1:0]    in_data;
    logic             start;
    logic             output_en;
    logic [IW-1:0]    output_sel;
    logic [ACC_W-1:0] out_data;
    logic             busy;
    logic             done;

    modport master (
        output load_en, load_sel_ab, load_index, in_data, start, output_en, output_sel,
        input  out_data, busy, done
    );

    modport slave (
        input  load_en, load_sel_ab, load_index, in_data, start, output_en, output_sel,
        output out_data, busy, done
    );

endinterface

// File: rtl/matmul_mac.sv
// Combinational DW x DW multiply with ACC_W accumulate.
// TPU_SIGNED_EN selects two's-complement operands with sign-extended products.
module matmul_mac #(
    parameter int DW    = 8,
    parameter int ACC_W = 17
) (
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    input  logic [ACC_W-1:0] acc_in,
    input  logic             clear,
    output logic [ACC_W-1:0] acc_out
);

    logic [2*DW-1:0]  prod;
    logic [ACC_W-1:0] prod_ext;

    always_comb begin
`ifdef TPU_SIGNED_EN
        prod     = $signed(a) * $signed(b);
        prod_ext = {{(ACC_W - 2 * DW){prod[2*DW-1]}}, prod};
`else
        prod     = a * b;
        prod_ext = ACC_W'(prod);
`endif
        acc_out  = (clear ? '0 : acc_in) + prod_ext;
    end

endmodule

// File: rtl/matmul_ctrl.sv
// N x N matrix-multiply controller: operand storage, i/j/k sequencing and result readback.
// Optional signed arithmetic via TPU_SIGNED_EN (handled in matmul_mac).
module matmul_ctrl
    import tpu_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DW    = DEF_DW,
    parameter int ACC_W = 2 * DW + $clog2(N),
    parameter int IW    = idx_w(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    matmul_ctrl_if.slave   bus
);

    localparam int unsigned NN   = N * N;
    localparam int          CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t state_q, state_d;

    logic [DW-1:0]    mat_a [NN];
    logic [DW-1:0]    mat_b [NN];
    logic [ACC_W-1:0] mat_c [NN];

    logic [CW-1:0]    i_q, j_q, k_q;
    logic [ACC_W-1:0] acc_q, acc_nxt;
    logic [IW-1:0]    a_idx, b_idx, c_idx;
    logic             idle_like, load_ok, read_ok, k_last, j_last, i_last;

    assign idle_like = (state_q != COMPUTE);
    assign load_ok   = idle_like && bus.load_en && (int'(bus.load_index) < int'(NN));
    assign read_ok   = (int'(bus.output_sel) < int'(NN));
    assign k_last    = (k_q == LAST);
    assign j_last    = (j_q == LAST);
    assign i_last    = (i_q == LAST);
    assign a_idx     = IW'(int'(i_q) * N + int'(k_q));
    assign b_idx     = IW'(int'(k_q) * N + int'(j_q));
    assign c_idx     = IW'(int'(i_q) * N + int'(j_q));
    assign bus.busy  = (state_q == COMPUTE);
    assign bus.done  = (state_q == DONE);

    matmul_mac #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .a       (mat_a[a_idx]),
        .b       (mat_b[b_idx]),
        .acc_in  (acc_q),
        .clear   (k_q == '0),
        .acc_out (acc_nxt)
    );

    // start outranks a same-cycle load for the next state; the load still lands
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start)
                    state_d = COMPUTE;
                else if (load_ok && state_q == DONE)
                    state_d = IDLE;
            end
            COMPUTE: begin
                if (i_last && j_last && k_last)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned e = 0; e < NN; e++) begin
                mat_a[e] <= '0;
                mat_b[e] <= '0;
                mat_c[e] <= '0;
            end
        end else begin
            if (load_ok) begin
                if (bus.load_sel_ab)
                    mat_b[bus.load_index] <= bus.in_data;
                else
                    mat_a[bus.load_index] <= bus.in_data;
            end
            if (state_q == COMPUTE && k_last)
                mat_c[c_idx] <= acc_nxt;
        end
    end

    // counters wrap to zero on the final term, so every compute begins at (0,0,0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
        end else if (state_q == COMPUTE) begin
            acc_q <= acc_nxt;
            if (k_last) begin
                k_q <= '0;
                if (j_last) begin
                    j_q <= '0;
                    i_q <= i_last ? '0 : i_q + 1'b1;
                end else begin
                    j_q <= j_q + 1'b1;
                end
            end else begin
                k_q <= k_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.out_data <= '0;
        else if (idle_like && bus.output_en)
            bus.out_data <= read_ok ? mat_c[bus.output_sel] : '0;
    end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl: an N=2 and an N=3 instance against a matrix-level model.
// Honours TPU_SIGNED_EN for operand interpretation and expected values.
module tb_matmul_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    logic       ld_en  [2];
    logic       ld_sel [2];
    logic [3:0] ld_idx [2];
    logic [7:0] din    [2];
    logic       st     [2];
    logic       oe     [2];
    logic [3:0] o_sel  [2];

    logic [17:0] d_out  [2];
    logic        d_busy [2];
    logic        d_done [2];

    matmul_ctrl_if #(.N(2), .DW(8), .ACC_W(17)) bus0 ();
    matmul_ctrl_if #(.N(3), .DW(8), .ACC_W(18)) bus1 ();

    assign bus0.load_en     = ld_en[0];
    assign bus0.load_sel_ab = ld_sel[0];
    assign bus0.load_index  = ld_idx[0][1:0];
    assign bus0.in_data     = din[0];
    assign bus0.start       = st[0];
    assign bus0.output_en   = oe[0];
    assign bus0.output_sel  = o_sel[0][1:0];
    assign d_out[0]         = 18'(bus0.out_data);
    assign d_busy[0]        = bus0.busy;
    assign d_done[0]        = bus0.done;

    assign bus1.load_en     = ld_en[1];
    assign bus1.load_sel_ab = ld_sel[1];
    assign bus1.load_index  = ld_idx[1];
    assign bus1.in_data     = din[1];
    assign bus1.start       = st[1];
    assign bus1.output_en   = oe[1];
    assign bus1.output_sel  = o_sel[1];
    assign d_out[1]         = bus1.out_data;
    assign d_busy[1]        = bus1.busy;
    assign d_done[1]        = bus1.done;

    matmul_ctrl #(.N(2), .DW(8), .ACC_W(17)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    matmul_ctrl #(.N(3), .DW(8), .ACC_W(18)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    // ---------------- matrix-level model ----------------
    longint ma [2][9];
    longint mb [2][9];
    longint mc [2][9];
    longint pend [2][9];
    int     bcnt [2];
    bit     mdone [2];
    longint mout [2];

    function automatic longint conv(input logic [7:0] v);
`ifdef TPU_SIGNED_EN
        return longint'($signed(v));
`else
        return longint'(v);
`endif
    endfunction

    function automatic int dim(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic longint mask(input int d);
        return (longint'(1) << ((d == 0) ? 17 : 18)) - 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            int n;
            n = dim(d);
            if (!rst_n) begin
                for (int e = 0; e < 9; e++) begin
                    ma[d][e] = 0; mb[d][e] = 0; mc[d][e] = 0; pend[d][e] = 0;
                end
                bcnt[d] = 0; mdone[d] = 0; mout[d] = 0;
            end else if (bcnt[d] > 0) begin
                bcnt[d]--;
                if (bcnt[d] == 0) begin
                    for (int e = 0; e < 9; e++) mc[d][e] = pend[d][e];
                    mdone[d] = 1;
                end
            end else begin
                if (ld_en[d] && int'(ld_idx[d]) < n * n) begin
                    if (ld_sel[d]) mb[d][ld_idx[d]] = conv(din[d]);
                    else           ma[d][ld_idx[d]] = conv(din[d]);
                    mdone[d] = 0;
                end
                if (oe[d])
                    mout[d] = (int'(o_sel[d]) < n * n) ? mc[d][o_sel[d]] : 0;
                if (st[d]) begin
                    for (int r = 0; r < n; r++)
                        for (int c = 0; c < n; c++) begin
                            longint s;
                            s = 0;
                            for (int k = 0; k < n; k++) s += ma[d][r*n+k] * mb[d][k*n+c];
                            pend[d][r*n+c] = s;
                        end
                    bcnt[d]  = n * n * n;
                    mdone[d] = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int d, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", nm, d, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk("model_busy", d, longint'(d_busy[d]), longint'(bcnt[d] > 0));
            chk("model_done", d, longint'(d_done[d]), longint'(mdone[d]));
            chk("model_out",  d, longint'(d_out[d]),  mout[d] & mask(d));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input int d, input bit le, input bit sel, input int idx, input int val,
                         input bit s, input bit o, input int oidx);
        @(negedge clk);
        ld_en[d] = le; ld_sel[d] = sel; ld_idx[d] = 4'(idx); din[d] = 8'(val);
        st[d] = s; oe[d] = o; o_sel[d] = 4'(oidx);
        @(posedge clk);
        #1;
        ld_en[d] = 1'b0; st[d] = 1'b0; oe[d] = 1'b0;
    endtask

    task automatic op_load(input int d, input bit sel, input int idx, input int val);
        drive(d, 1'b1, sel, idx, val, 1'b0, 1'b0, 0);
    endtask

    task automatic op_start(input int d);
        drive(d, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 0);
    endtask

    task automatic op_read(input int d, input int idx, input longint exp);
        drive(d, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, idx);
        chk("read", d, longint'(d_out[d]), exp);
    endtask

    task automatic wait_done(input int d, input int t0, input int exp_cycles);
        while (!d_done[d] && cyc - t0 < 200) begin
            @(posedge clk);
            #1;
        end
        chk("done_seen", d, longint'(d_done[d]), 1);
        chk("cycles", d, longint'(cyc - t0), longint'(exp_cycles));
    endtask

    task automatic load_all(input int d, input int n, input int a0, input int b0, input bit uniform);
        for (int e = 0; e < n * n; e++) begin
            op_load(d, 1'b0, e, uniform ? a0 : a0 + e);
            op_load(d, 1'b1, e, uniform ? b0 : b0 + e);
        end
    endtask

    longint exp_max, exp_sgn;
    int     t0;

    initial begin
`ifdef TPU_SIGNED_EN
        exp_max = 2;
        exp_sgn = 17'h1FFFC;
`else
        exp_max = 130050;
        exp_sgn = 1020;
`endif
        for (int d = 0; d < 2; d++) begin
            ld_en[d] = 0; ld_sel[d] = 0; ld_idx[d] = 0; din[d] = 0;
            st[d] = 0; oe[d] = 0; o_sel[d] = 0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", d, longint'(d_busy[d]), 0);
            chk("rst_done", d, longint'(d_done[d]), 0);
            chk("rst_out",  d, longint'(d_out[d]), 0);
        end
        rst_n = 1'b1;

        // A=[[1,2],[3,4]], B=[[5,6],[7,8]]
        load_all(0, 2, 1, 5, 1'b0);
        op_start(0);
        t0 = cyc;
        chk("busy_after_start", 0, longint'(d_busy[0]), 1);
        wait_done(0, t0, 8);
        chk("busy_after_done", 0, longint'(d_busy[0]), 0);
        op_read(0, 0, 19);
        op_read(0, 1, 22);
        op_read(0, 2, 43);
        op_read(0, 3, 50);

        // loads, start and read while computing are all ignored
        op_start(0);
        t0 = cyc;
        op_load(0, 1'b0, 0, 9);
        op_start(0);
        op_read(0, 0, 50);
        wait_done(0, t0, 8);
        op_read(0, 0, 19);
        op_read(0, 3, 50);

        // all-255 operands: no wrap at minimum accumulator width
        op_load(0, 1'b0, 0, 255);
        chk("load_clears_done", 0, longint'(d_done[0]), 0);
        load_all(0, 2, 255, 255, 1'b1);
        op_start(0);
        t0 = cyc;
        wait_done(0, t0, 8);
        op_read(0, 0, exp_max);
        op_read(0, 3, exp_max);

        // A all 0xFF, B all 0x02
        load_all(0, 2, 255, 2, 1'b1);
        op_start(0);
        t0 = cyc;
        wait_done(0, t0, 8);
        op_read(0, 1, exp_sgn);
        op_read(0, 2, exp_sgn);

        // N=3: identity times 1..9, plus out-of-range load and read
        for (int e = 0; e < 9; e++) begin
            op_load(1, 1'b0, e, (e % 4 == 0) ? 1 : 0);
            op_load(1, 1'b1, e, e + 1);
        end
        op_load(1, 1'b0, 9, 77);
        op_start(1);
        t0 = cyc;
        wait_done(1, t0, 27);
        for (int e = 0; e < 9; e++) op_read(1, e, e + 1);
        op_read(1, 9, 0);

        // reset three cycles into a compute
        op_start(0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 0, longint'(d_busy[0]), 0);
        chk("midrst_done", 0, longint'(d_done[0]), 0);
        chk("midrst_out",  0, longint'(d_out[0]), 0);
        chk("midrst_out",  1, longint'(d_out[1]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        op_read(0, 0, 0);
        op_read(0, 3, 0);
        op_read(1, 8, 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
